// File: rtl/fb_delay_align.sv
// fb_delay_align: feedback loop-delay estimator and aligner.
// Cross-correlates |ref| against |fb| over LAG_MIN..LAG_MAX. The lag with the
// largest metric is committed, and the reference is then replayed delayed by
// that lag alongside the feedback.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start
// FILL  | waiting for the reference buffer to hold LAG_MAX+2 samples
// ACC   | issuing 2^LOG2N products for the current candidate lag
// FLSH  | 2 cycles draining the magnitude/product pipeline into the accumulator
// CMP   | compare accumulator against best, then advance candidate
// DONE  | final compare for LAG_MAX, commit lag if best > 0, pulse done
module fb_delay_align #(
    parameter int AW      = 10,
    parameter int LAG_MIN = 0,
    parameter int LAG_MAX = 1000,
    parameter int LOG2N   = 8
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 start,
    input  logic signed [19:0]   sig_ref_i,
    input  logic signed [19:0]   sig_ref_q,
    input  logic signed [19:0]   sig_fb_i,
    input  logic signed [19:0]   sig_fb_q,
    output logic signed [19:0]   sig_ref_al_i,
    output logic signed [19:0]   sig_ref_al_q,
    output logic signed [19:0]   sig_fb_al_i,
    output logic signed [19:0]   sig_fb_al_q,
    output logic [AW-1:0]        lag,
    output logic                 busy,
    output logic                 done,
    output logic                 lock
);

    localparam int DEPTH = 1 << AW;
    localparam int ACCW  = 42 + LOG2N;
    localparam int CW    = LOG2N + 1;
    localparam logic [AW-1:0] FILL_FULL = AW'(LAG_MAX + 2);
    localparam logic [AW-1:0] LAG_MIN_V = AW'(LAG_MIN);
    localparam logic [AW-1:0] LAG_MAX_V = AW'(LAG_MAX);
    localparam logic [CW-1:0] ACC_LOAD  = CW'((1 << LOG2N) - 1);
    localparam logic [CW-1:0] FLSH_LOAD = CW'(1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_ACC, S_FLSH, S_CMP, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [39:0]         r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_fill, r_cand, r_best_lag;
    logic [CW-1:0]       r_cnt;
    logic signed [19:0]  r_fb_d1_i, r_fb_d1_q;
    logic                r_v1, r_v2;
    logic [20:0]         r_mr, r_mf;
    logic [41:0]         r_prod;
    logic [ACCW-1:0]     r_acc, r_best;
    logic [AW-1:0]       w_al_addr, w_srch_addr, w_blag_nxt;
    logic [39:0]         w_al_word, w_srch_word;
    logic [ACCW-1:0]     w_best_nxt;
    logic                w_gt, w_enter_acc;

    // |i| + |q| as an exact 21-bit unsigned value, including -2^19
    function automatic logic [20:0] mag(input logic signed [19:0] a, input logic signed [19:0] b);
        logic [20:0] aa, ab;
        aa = a[19] ? (21'd0 - {1'b1, a}) : {1'b0, a};
        ab = b[19] ? (21'd0 - {1'b1, b}) : {1'b0, b};
        return aa + ab;
    endfunction

    assign w_al_addr   = r_wr_ptr - AW'(1) - lag;
    assign w_srch_addr = r_wr_ptr - AW'(1) - r_cand;
    assign w_al_word   = r_mem[w_al_addr];
    assign w_srch_word = r_mem[w_srch_addr];
    assign w_gt        = r_acc > r_best;
    assign w_best_nxt  = w_gt ? r_acc : r_best;
    assign w_blag_nxt  = w_gt ? r_cand : r_best_lag;
    assign w_enter_acc = (w_state_nxt == S_ACC) && (r_state != S_ACC);

    // Reference history: written every cycle, no reset (masked by fill count)
    always_ff @(posedge clk) begin
        r_mem[r_wr_ptr] <= {sig_ref_i, sig_ref_q};
    end

    // Write pointer and saturating fill counter
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_ptr <= '0;
            r_fill   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (r_fill != FILL_FULL) r_fill <= r_fill + AW'(1);
        end
    end

    // Aligned outputs: feedback delayed 2, reference delayed 2+lag
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_fb_d1_i    <= '0;
            r_fb_d1_q    <= '0;
            sig_fb_al_i  <= '0;
            sig_fb_al_q  <= '0;
            sig_ref_al_i <= '0;
            sig_ref_al_q <= '0;
        end else begin
            r_fb_d1_i   <= sig_fb_i;
            r_fb_d1_q   <= sig_fb_q;
            sig_fb_al_i <= r_fb_d1_i;
            sig_fb_al_q <= r_fb_d1_q;
            if (r_fill > lag) begin
                sig_ref_al_i <= w_al_word[39:20];
                sig_ref_al_q <= w_al_word[19:0];
            end else begin
                sig_ref_al_i <= '0;
                sig_ref_al_q <= '0;
            end
        end
    end

    // Correlation pipeline: magnitudes, product, accumulate
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_mr   <= '0;
            r_mf   <= '0;
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            r_v1   <= (r_state == S_ACC);
            r_mr   <= mag(w_srch_word[39:20], w_srch_word[19:0]);
            r_mf   <= mag(r_fb_d1_i, r_fb_d1_q);
            r_v2   <= r_v1;
            r_prod <= {21'd0, r_mr} * {21'd0, r_mf};
            if (w_enter_acc) r_acc <= '0;
            else if (r_v2)   r_acc <= r_acc + {{LOG2N{1'b0}}, r_prod};
        end
    end

    // Down-counter timing ACC length and the pipeline flush
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)                          r_cnt <= '0;
        else if (w_enter_acc)                  r_cnt <= ACC_LOAD;
        else if (r_state == S_ACC && r_cnt == '0) r_cnt <= FLSH_LOAD;
        else if (r_cnt != '0)                  r_cnt <= r_cnt - CW'(1);
    end

    // Candidate / best tracking and lag commit
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cand     <= LAG_MIN_V;
            r_best     <= '0;
            r_best_lag <= LAG_MIN_V;
            lag        <= LAG_MIN_V;
            lock       <= 1'b0;
        end else begin
            if (w_enter_acc && r_state != S_CMP) begin
                r_cand     <= LAG_MIN_V;
                r_best     <= '0;
                r_best_lag <= lag;
            end else if (r_state == S_CMP) begin
                r_best     <= w_best_nxt;
                r_best_lag <= w_blag_nxt;
                r_cand     <= r_cand + AW'(1);
            end
            if (r_state == S_DONE && w_best_nxt != '0) begin
                lag  <= w_blag_nxt;
                lock <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state logic; the last lag's compare is folded into DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = (r_fill == FILL_FULL) ? S_ACC : S_FILL;
            S_FILL: if (r_fill == FILL_FULL) w_state_nxt = S_ACC;
            S_ACC:  if (r_cnt == '0) w_state_nxt = S_FLSH;
            S_FLSH: if (r_cnt == '0) w_state_nxt = (r_cand == LAG_MAX_V) ? S_DONE : S_CMP;
            S_CMP:  w_state_nxt = S_ACC;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

endmodule

// File: tb/tb_fb_delay_align.sv
// Directed testbench for fb_delay_align (AW=7, lags 0..63, 64-sample window).
// Reference magnitudes follow a ramp that is periodic over a full window, so
// the correlation peak at the true delay is strict and deterministic.
module tb_fb_delay_align;

    localparam int AW = 7, LAG_MIN = 0, LAG_MAX = 63, LOG2N = 6;
    localparam int SEARCH_CYC = (LAG_MAX - LAG_MIN + 1) * ((1 << LOG2N) + 3);

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    logic start = 1'b0;
    logic signed [19:0] ref_i = '0, ref_q = '0, fb_i = '0, fb_q = '0;
    logic signed [19:0] ref_al_i, ref_al_q, fb_al_i, fb_al_q;
    logic [AW-1:0] lag;
    logic busy, done, lock;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cur    = 0;
    int mode_delay  = 37;
    int mode_period = 64;
    bit mode_silent = 1'b1;
    logic signed [19:0] h_ri [256];
    logic signed [19:0] h_rq [256];
    logic signed [19:0] h_fi [256];
    logic signed [19:0] h_fq [256];

    fb_delay_align #(.AW(AW), .LAG_MIN(LAG_MIN), .LAG_MAX(LAG_MAX), .LOG2N(LOG2N)) dut (
        .clk(clk), .reset_b(reset_b), .start(start),
        .sig_ref_i(ref_i), .sig_ref_q(ref_q), .sig_fb_i(fb_i), .sig_fb_q(fb_q),
        .sig_ref_al_i(ref_al_i), .sig_ref_al_q(ref_al_q),
        .sig_fb_al_i(fb_al_i), .sig_fb_al_q(fb_al_q),
        .lag(lag), .busy(busy), .done(done), .lock(lock)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_sample();
        int k;
        logic signed [19:0] amp, ri, rq, fi, fq;
        k   = n_cur % mode_period;
        amp = 20'(2000 * (k + 1));
        ri  = ($urandom_range(0, 1) == 1) ? -amp : amp;
        rq  = ($urandom_range(0, 1) == 1) ? -amp : amp;
        h_ri[n_cur % 256] = ri;
        h_rq[n_cur % 256] = rq;
        if (mode_silent || n_cur < mode_delay) begin
            fi = '0;
            fq = '0;
        end else begin
            fi = h_ri[(n_cur - mode_delay) % 256] >>> 1;
            fq = h_rq[(n_cur - mode_delay) % 256] >>> 1;
        end
        h_fi[n_cur % 256] = fi;
        h_fq[n_cur % 256] = fq;
        ref_i = ri; ref_q = rq; fb_i = fi; fb_q = fq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_cur++;
        drive_sample();
    endtask

    // Pulses start, then counts busy cycles and done pulses until busy falls.
    task automatic run_search(input int second_at, output int busy_cyc, output int done_cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        for (int c = 0; c < 20000 && busy; c++) begin
            busy_cyc++;
            if (done) done_cnt++;
            if (c == second_at) start = 1'b1;
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            ref_i = 20'($urandom); ref_q = 20'($urandom);
            fb_i  = 20'($urandom); fb_q  = 20'($urandom);
        end
        n_checks++; if ({ref_al_i, ref_al_q} !== 40'd0) begin n_fail++; $display("FAIL reset_ref_al got %h want 0", {ref_al_i, ref_al_q}); end
        n_checks++; if ({fb_al_i, fb_al_q} !== 40'd0) begin n_fail++; $display("FAIL reset_fb_al got %h want 0", {fb_al_i, fb_al_q}); end
        n_checks++; if (lag !== AW'(LAG_MIN)) begin n_fail++; $display("FAIL reset_lag got %0d want %0d", lag, LAG_MIN); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL reset_lock got %b want 0", lock); end
        reset_b = 1'b1;
    endtask

    task automatic test_silent();
        int b, d;
        mode_silent = 1'b1;
        repeat (200) tick();
        run_search(-1, b, d);
        n_checks++; if (b !== SEARCH_CYC) begin n_fail++; $display("FAIL silent_busy got %0d want %0d", b, SEARCH_CYC); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL silent_done got %0d want 1", d); end
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL silent_lock got %b want 0", lock); end
        n_checks++; if (lag !== 7'd0) begin n_fail++; $display("FAIL silent_lag got %0d want 0", lag); end
    endtask

    task automatic test_known_delay();
        int b, d;
        mode_silent = 1'b0; mode_period = 64; mode_delay = 37;
        repeat (200) tick();
        run_search(-1, b, d);
        n_checks++; if (b !== SEARCH_CYC) begin n_fail++; $display("FAIL known_busy got %0d want %0d", b, SEARCH_CYC); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL known_done got %0d want 1", d); end
        n_checks++; if (lag !== 7'd37) begin n_fail++; $display("FAIL known_lag got %0d want 37", lag); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL known_lock got %b want 1", lock); end
        for (int c = 0; c < 100; c++) begin
            tick();
            n_checks++;
            if ({fb_al_i, fb_al_q} !== {h_fi[(n_cur - 2) % 256], h_fq[(n_cur - 2) % 256]}) begin
                n_fail++;
                $display("FAIL align_fb got %0d/%0d want %0d/%0d", fb_al_i, fb_al_q,
                         h_fi[(n_cur - 2) % 256], h_fq[(n_cur - 2) % 256]);
            end
            n_checks++;
            if ({ref_al_i, ref_al_q} !== {h_ri[(n_cur - 39) % 256], h_rq[(n_cur - 39) % 256]}) begin
                n_fail++;
                $display("FAIL align_ref got %0d/%0d want %0d/%0d", ref_al_i, ref_al_q,
                         h_ri[(n_cur - 39) % 256], h_rq[(n_cur - 39) % 256]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b, d, extra;
        mode_period = 64; mode_delay = 10;
        repeat (200) tick();
        run_search(1000, b, d);
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            if (busy) extra++;
            tick();
        end
        n_checks++; if (b !== SEARCH_CYC) begin n_fail++; $display("FAIL b2b_busy got %0d want %0d", b, SEARCH_CYC); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL b2b_done got %0d want 1", d); end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL b2b_restart got %0d busy cycles want 0", extra); end
        n_checks++; if (lag !== 7'd10) begin n_fail++; $display("FAIL b2b_lag got %0d want 10", lag); end
    endtask

    task automatic test_wrap_max();
        int b, d;
        mode_period = 64; mode_delay = 63;
        repeat (1000) tick();
        run_search(-1, b, d);
        n_checks++; if (lag !== 7'd63) begin n_fail++; $display("FAIL wrap_lag got %0d want 63", lag); end
        n_checks++; if (b !== SEARCH_CYC) begin n_fail++; $display("FAIL wrap_busy got %0d want %0d", b, SEARCH_CYC); end
    endtask

    task automatic test_zero_delay();
        int b, d;
        mode_period = 64; mode_delay = 0;
        repeat (200) tick();
        run_search(-1, b, d);
        n_checks++; if (lag !== 7'd0) begin n_fail++; $display("FAIL zero_lag got %0d want 0", lag); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL zero_lock got %b want 1", lock); end
    endtask

    task automatic test_tie();
        int b, d;
        mode_period = 16; mode_delay = 5;
        repeat (200) tick();
        run_search(-1, b, d);
        n_checks++; if (lag !== 7'd5) begin n_fail++; $display("FAIL tie_lag got %0d want 5", lag); end
    endtask

    task automatic test_start_early();
        int b, d, want;
        mode_period = 64; mode_delay = 37;
        reset_b = 1'b0;
        repeat (2) tick();
        reset_b = 1'b1;
        tick();
        tick();
        // start is sampled on the 3rd edge after release; FILL lasts until
        // the cycle in which the fill count reads LAG_MAX+2
        run_search(-1, b, d);
        want = (LAG_MAX + 2) - 3 + 1 + SEARCH_CYC;
        n_checks++; if (b !== want) begin n_fail++; $display("FAIL early_busy got %0d want %0d", b, want); end
        n_checks++; if (d !== 1) begin n_fail++; $display("FAIL early_done got %0d want 1", d); end
        n_checks++; if (lag !== 7'd37) begin n_fail++; $display("FAIL early_lag got %0d want 37", lag); end
    endtask

    task automatic test_reset_mid();
        int b, d;
        mode_period = 64; mode_delay = 20;
        repeat (200) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (500) tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy); end
        reset_b = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
        n_checks++; if (lag !== AW'(LAG_MIN)) begin n_fail++; $display("FAIL mid_lag got %0d want %0d", lag, LAG_MIN); end
        n_checks++; if (lock !== 1'b0) begin n_fail++; $display("FAIL mid_lock got %b want 0", lock); end
        n_checks++; if ({ref_al_i, fb_al_i} !== 40'd0) begin n_fail++; $display("FAIL mid_data got %h want 0", {ref_al_i, fb_al_i}); end
        tick();
        reset_b = 1'b1;
        repeat (100) tick();
        run_search(-1, b, d);
        n_checks++; if (b !== SEARCH_CYC) begin n_fail++; $display("FAIL mid_rerun_busy got %0d want %0d", b, SEARCH_CYC); end
        n_checks++; if (lag !== 7'd20) begin n_fail++; $display("FAIL mid_rerun_lag got %0d want 20", lag); end
        n_checks++; if (lock !== 1'b1) begin n_fail++; $display("FAIL mid_rerun_lock got %b want 1", lock); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            h_ri[k] = '0; h_rq[k] = '0; h_fi[k] = '0; h_fq[k] = '0;
        end
        test_reset();
        test_silent();
        test_known_delay();
        test_back_to_back();
        test_wrap_max();
        test_zero_delay();
        test_tie();
        test_start_early();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_delay_align.md
# fb_delay_align

Feedback-path loop-delay estimator and aligner placed between the PA-output capture path and the `sig_pa_i/q` port of `dpd`. It cross-correlates the magnitude of the DPD reference input against the PA feedback over a programmable lag range. It commits the lag with maximum correlation, then outputs the reference delayed by that lag next to the feedback, so `dpd` sees time-aligned pairs. This replaces the fixed `DELAY` parameter tuning with a run-time search.

## Interface
- `AW`, 10: reference buffer address width; the buffer depth is 2^AW samples.
- `LAG_MIN`, 0: first lag searched, in cycles.
- `LAG_MAX`, 1000: last lag searched. Required: LAG_MIN <= LAG_MAX <= 2^AW-3.
- `LOG2N`, 8: correlation window of 2^LOG2N samples per lag.

- `clk`, in, 1: clock.
- `reset_b`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle request to run a search.
- `sig_ref_i`, `sig_ref_q`, in, s20: reference (DPD input) samples, one per cycle.
- `sig_fb_i`, `sig_fb_q`, in, s20: PA feedback samples, one per cycle.
- `sig_ref_al_i`, `sig_ref_al_q`, out, s20: reference delayed by the committed lag.
- `sig_fb_al_i`, `sig_fb_al_q`, out, s20: feedback, pipeline-matched.
- `lag`, out, AW: committed lag.
- `busy`, out, 1: a search is pending or running.
- `done`, out, 1: one-cycle pulse at search end.
- `lock`, out, 1: a valid lag has been committed since reset.

## Operation
- Reference buffer: sig_ref is written every cycle at `wr_ptr`, which increments and wraps mod 2^AW. There are two read ports: an align port at the committed lag and a search port at the candidate lag. The fill counter counts writes since reset and saturates at LAG_MAX+2.
- Magnitude: m = |i| + |q|, unsigned 21 bit; |-524288| = 524288 is exact. Product p = m_ref(delayed) * m_fb, 42 bit. Accumulator is 42+LOG2N bit, wraps never. The metric is gain-insensitive for argmax.
- FSM states:
  - IDLE: `start` -> FILL.
  - FILL: waits until fill count = LAG_MAX+2 (passes through immediately if already full) -> ACC with candidate = LAG_MIN, best = 0, best_lag = current `lag`.
  - ACC: 2^LOG2N products accumulated for the candidate -> CMP after the 2-cycle pipeline flush.
  - CMP, 1 cycle: if acc > best (strict), then best = acc and best_lag = candidate. Ties keep the smaller lag. If candidate = LAG_MAX -> DONE; else candidate+1, accumulator cleared -> ACC.
  - DONE, 1 cycle: if best > 0, then `lag` = best_lag and `lock` = 1. If best = 0 (e.g. silent feedback), `lag` and `lock` are unchanged. `done` pulses -> IDLE.
- `busy` = 1 in FILL, ACC, CMP and DONE.
- `start` in any state other than IDLE is ignored and not queued.
- The align path always uses the committed `lag`. The lag update takes effect on the cycle after DONE; there is no output glitch other than the lag step itself.

## Timing
- Reset values: all data outputs 0; `lag` = LAG_MIN; `busy`, `done`, `lock` = 0; FSM in IDLE; `wr_ptr` and fill counter 0. Buffer contents are don't-care because they are masked by the fill counter.
- Align latency: sig_fb_al(t) = sig_fb(t-2); sig_ref_al(t) = sig_ref(t-2-lag). Both are registered outputs.
- Search correlates m_ref(n-L) with m_fb(n), with the same definition of L as `lag`.
- Search duration from leaving FILL to the `done` pulse is exactly (LAG_MAX-LAG_MIN+1)*(2^LOG2N+3) cycles. The per-lag cost is 2^LOG2N ACC cycles + 2 flush cycles + 1 CMP cycle; DONE is the final cycle.
- Read address = wr_ptr - 1 - L mod 2^AW. Wrap is seamless across the pointer rollover.
- An asynchronous reset mid-search immediately returns all outputs to their reset values, and the search is aborted.
- `dpd_adapt` must only be asserted when `lock` = 1. This is a system rule; the block does not enforce it.

## Test plan
- Reset: hold reset_b=0 for 4 cycles with random inputs -> all outputs 0, lag=LAG_MIN, busy=done=lock=0.
- Known delay: AW=7, LAG_MIN=0, LAG_MAX=63, LOG2N=6, fb = ref delayed 37 cycles and shifted right by 1, random QPSK-like ref; start after 200 cycles. Required response:
  - busy for exactly 64*67 cycles.
  - done pulse with lag=37 and lock=1.
  - Afterwards, sig_ref_al equals 2*sig_fb_al ±1 LSB every cycle.
- Silent feedback: fb=0, start -> done after 64*67 cycles, lock stays 0, lag stays 0.
- Start handling:
  - start at cycle 3 after reset -> FILL holds until 65 writes; total busy = FILL wait + 64*67.
  - Second start pulse mid-search -> no restart; exactly one done.
- Boundary/wrap: delay = LAG_MAX = 63, search launched after 1000 cycles (several pointer wraps) -> lag=63. Delay = 0 -> lag=0. Equal-metric tie (periodic ref with period 16, delay 5) -> lag=5, the smallest tied lag.
- Reset mid-search: assert reset_b=0 for 1 cycle, 500 cycles into the search. Required response:
  - busy falls and lag returns to LAG_MIN asynchronously.
  - A new start completes normally with the correct lag.
